// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: idle word, column drive patterns,
// FSM states and frame helper functions.
package keypad_scan_pkg;

    localparam logic [15:0] KEY_IDLE = 16'h00FF;

    localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LOCK
    } scanState_t;

    function automatic logic [4:0] countKeys(input logic [15:0] frame);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + 5'(frame[i]);
        end
        return n;
    endfunction

    // Frame bit index is col*4+row; the press code is row*4+col.
    function automatic logic [3:0] keyCode(input logic [15:0] frame);
        logic [3:0] code;
        logic [3:0] idx;
        code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = 4'(i);
            if (frame[i]) begin
                code = {idx[1:0], idx[3:2]};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-code bundle between the scanner and its neighbours.
interface keypad_scan_if;
    logic [3:0]  iRow;
    logic [3:0]  oCol;
    logic [15:0] key_num;
    logic        oKey_valid;

    modport master (
        input  iRow,
        output oCol,
        output key_num,
        output oKey_valid
    );

    modport slave (
        output iRow,
        input  oCol,
        input  key_num,
        input  oKey_valid
    );
endinterface

// File: rtl/keypad_scan_col_drv.sv
// Column stepping for the keypad: scan divider, column counter, column
// decode and a two-flop row synchroniser (rows returned active-high).
module keypad_col_drv
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [3:0] iRow,
    output logic [3:0] oCol,
    output logic       tick,
    output logic [1:0] col,
    output logic [3:0] rows
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] divCnt;
    logic [3:0]    rowMeta;
    logic [3:0]    rowSync;

    assign tick = (divCnt == DW'(SCAN_DIV - 1));

    // Synchroniser resets to the released level so no phantom press follows reset.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            divCnt  <= '0;
            col     <= '0;
            rowMeta <= '1;
            rowSync <= '1;
        end else begin
            rowMeta <= iRow;
            rowSync <= rowMeta;
            if (tick) begin
                divCnt <= '0;
                col    <= col + 2'd1;
            end else begin
                divCnt <= divCnt + DW'(1);
            end
        end
    end

    assign rows = ~rowSync;
    assign oCol = COL_DRIVE[col];

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: assembles whole-matrix frames, debounces them and
// emits a one-cycle code for each new single-key press.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_FRAMES = 5
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    keypad_scan_if.master bus
);

    localparam int             DBW    = (DB_FRAMES > 1) ? $clog2(DB_FRAMES) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_FRAMES - 1);

    logic           tick;
    logic [1:0]     col;
    logic [3:0]     rows;
    logic [15:0]    curFrame;
    logic [15:0]    prevFrame;
    logic [15:0]    doneFrame;
    logic [DBW-1:0] dbCnt;
    logic [DBW-1:0] dbNext;
    logic           frameEnd;
    logic           stableEvt;
    logic [4:0]     keyCnt;
    logic           emit;
    scanState_t     state;
    scanState_t     nextState;

    keypad_col_drv #(
        .SCAN_DIV(SCAN_DIV)
    ) uColDrv (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .iRow  (bus.iRow),
        .oCol  (bus.oCol),
        .tick  (tick),
        .col   (col),
        .rows  (rows)
    );

    assign frameEnd = tick && (col == 2'd3);

    // The completed frame includes the column-3 rows being stored on this tick.
    always_comb begin
        doneFrame         = curFrame;
        doneFrame[12 +: 4] = rows;
    end

    always_comb begin
        dbNext = '0;
        if (doneFrame == prevFrame) begin
            dbNext = (dbCnt == DB_MAX) ? dbCnt : dbCnt + DBW'(1);
        end
    end

    assign stableEvt = frameEnd && (dbNext == DB_MAX);
    assign keyCnt    = countKeys(doneFrame);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            curFrame  <= '0;
            prevFrame <= '0;
            dbCnt     <= '0;
        end else begin
            if (tick) begin
                curFrame[{col, 2'b00} +: 4] <= rows;
            end
            if (frameEnd) begin
                prevFrame <= doneFrame;
                dbCnt     <= dbNext;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (stableEvt) begin
            case (state)
                IDLE: begin
                    if (keyCnt == 5'd1) begin
                        nextState = HELD;
                    end else if (keyCnt > 5'd1) begin
                        nextState = LOCK;
                    end
                end
                HELD, LOCK: begin
                    if (keyCnt == 5'd0) begin
                        nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        emit = 1'b0;
        if (stableEvt && (state == IDLE) && (keyCnt == 5'd1)) begin
            emit = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            bus.key_num    <= KEY_IDLE;
            bus.oKey_valid <= 1'b0;
        end else begin
            bus.key_num    <= emit ? {12'h000, keyCode(doneFrame)} : KEY_IDLE;
            bus.oKey_valid <= emit;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad model that pulls row r low
// while column c is driven low and key (r,c) is held.
module tb_keypad_scan;

    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int FRAME = 4 * SD;

    logic        iCLK   = 1'b0;
    logic        iRST_n = 1'b0;
    logic [15:0] keys   = '0;
    logic [3:0]  colPat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    int          checks    = 0;
    int          failures  = 0;
    int          strobes   = 0;
    int          cyc       = 0;
    int          strobeCyc = 0;
    int          base;
    int          pressCyc;
    int          stopCyc;
    logic [15:0] lastCode  = 16'h00FF;

    keypad_scan_if bus();

    keypad_scan #(
        .SCAN_DIV (SD),
        .DB_FRAMES(DB)
    ) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    // keys bit index is row*4+col
    always_comb begin
        bus.iRow = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.oCol[c] && keys[r*4 + c]) begin
                    bus.iRow[r] = 1'b0;
                end
            end
        end
    end

    task automatic chkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge iCLK) begin
        cyc++;
        if (bus.oKey_valid === 1'b1) begin
            strobes++;
            lastCode  = bus.key_num;
            strobeCyc = cyc;
            chkEq("strobe_not_idle", 32'(bus.key_num != 16'h00FF), 1);
        end else begin
            chkEq("idle_word", 32'(bus.key_num), 32'h00FF);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
        #2;
    endtask

    // Leaves the bench on the first cycle of column 0 of a frame.
    task automatic alignFrame();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = bus.oCol;
        for (int i = 0; i < 24 && !found; i++) begin
            tick(1);
            if (prev == 4'h7 && bus.oCol == 4'hE) begin
                found = 1'b1;
            end
            prev = bus.oCol;
        end
        if (!found) begin
            chkEq("align_timeout", 0, 1);
        end
    endtask

    initial begin
        // 1: reset values and column stepping
        tick(3);
        chkEq("rst_col", 32'(bus.oCol), 32'hE);
        chkEq("rst_key", 32'(bus.key_num), 32'h00FF);
        chkEq("rst_valid", 32'(bus.oKey_valid), 0);
        iRST_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chkEq("col_step", 32'(bus.oCol), 32'(colPat[(k / 4) % 4]));
            tick(1);
        end

        // 2: held S1 strobes once; re-press strobes once more
        base     = strobes;
        keys     = 16'h0001;
        pressCyc = cyc;
        tick(10 * FRAME);
        chkEq("s1_count", 32'(strobes - base), 1);
        chkEq("s1_code", 32'(lastCode), 32'h0000);
        chkEq("s1_latency", 32'((strobeCyc - pressCyc) <= 3 * FRAME + 3), 1);
        keys = '0;
        tick(4 * FRAME);
        chkEq("s1_release_count", 32'(strobes - base), 1);
        keys = 16'h0001;
        tick(6 * FRAME);
        chkEq("s1_repress_count", 32'(strobes - base), 2);
        chkEq("s1_repress_code", 32'(lastCode), 32'h0000);
        keys = '0;
        tick(4 * FRAME);

        // 3: bouncing S2 then held
        alignFrame();
        base = strobes;
        for (int i = 0; i < 2 * FRAME; i++) begin
            keys = (((i / 3) % 2) == 0) ? 16'h0002 : 16'h0000;
            tick(1);
        end
        keys    = 16'h0002;
        stopCyc = cyc;
        tick(6 * FRAME);
        chkEq("s2_count", 32'(strobes - base), 1);
        chkEq("s2_code", 32'(lastCode), 32'h0001);
        chkEq("s2_not_early", 32'((strobeCyc - stopCyc) >= 2 * FRAME), 1);
        keys = '0;
        tick(4 * FRAME);

        // 4: S16 code must not look like the idle word
        base = strobes;
        keys = 16'h8000;
        tick(6 * FRAME);
        chkEq("s16_count", 32'(strobes - base), 1);
        chkEq("s16_code", 32'(lastCode), 32'h000F);
        keys = '0;
        tick(4 * FRAME);

        // 5: two keys lock out until everything is released
        base = strobes;
        keys = 16'h0003;
        tick(6 * FRAME);
        chkEq("multi_count", 32'(strobes - base), 0);
        keys = 16'h0001;
        tick(6 * FRAME);
        chkEq("lock_single_count", 32'(strobes - base), 0);
        keys = '0;
        tick(4 * FRAME);
        chkEq("lock_release_count", 32'(strobes - base), 0);
        keys = 16'h0004;
        tick(6 * FRAME);
        chkEq("s3_count", 32'(strobes - base), 1);
        chkEq("s3_code", 32'(lastCode), 32'h0002);
        keys = '0;
        tick(4 * FRAME);

        // 6: reset mid-debounce discards the pending press
        alignFrame();
        base = strobes;
        keys = 16'h0008;
        tick(20);
        chkEq("s4_pre_reset_count", 32'(strobes - base), 0);
        iRST_n = 1'b0;
        #1;
        chkEq("s4_rst_col", 32'(bus.oCol), 32'hE);
        chkEq("s4_rst_key", 32'(bus.key_num), 32'h00FF);
        chkEq("s4_rst_valid", 32'(bus.oKey_valid), 0);
        tick(4);
        iRST_n = 1'b1;
        chkEq("s4_in_reset_count", 32'(strobes - base), 0);
        tick(6 * FRAME);
        chkEq("s4_count", 32'(strobes - base), 1);
        chkEq("s4_code", 32'(lastCode), 32'h0003);
        keys = '0;
        tick(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
